// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared lane geometry, saturation limits and reduce-stage states
package simd_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;
  localparam int DATA_W = LANES * LANE_W;

  localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
  localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_add4.sv
// rtl/sat_add4.sv - combinational signed saturating add of one packed lane
module sat_add4
  import simd_pkg::*;
(
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] y,
  output logic              ovf
);

  logic [LANE_W-1:0] raw;

  always_comb begin
    raw = a + b;
    // Overflow only when both operands share a sign and the result flips it.
    ovf = (a[LANE_W-1] == b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
    if (ovf) begin
      y = a[LANE_W-1] ? SAT_NEG : SAT_POS;
    end else begin
      y = raw;
    end
  end

endmodule

// File: rtl/paddsb_reduce.sv
// rtl/paddsb_reduce.sv - lane-wise saturating burst reduction with sticky per-lane flags
module paddsb_reduce
  import simd_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LANES-1:0]  out_sat,
  output logic [CNT_W-1:0]  out_count
);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [LANES-1:0]   sat_q, sat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  sum;
  logic [LANES-1:0]   ovf;
  logic               accept;
  logic               load_out;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sat_add4 u_add (
      .a   (acc_q[l*LANE_W +: LANE_W]),
      .b   (in_data[l*LANE_W +: LANE_W]),
      .y   (sum[l*LANE_W +: LANE_W]),
      .ovf (ovf[l])
    );
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q != DONE);
    out_valid = (state_q == DONE);
    accept    = in_valid && in_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d = in_data;
          sat_d = '0;
          cnt_d = CNT_W'(1);
          if (in_last || MAX_BEATS == 1) state_d = DONE;
          else                           state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = sum;
          sat_d = sat_q | ovf;
          cnt_d = cnt_q + CNT_W'(1);
          if (in_last || cnt_d == CNT_W'(MAX_BEATS)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          sat_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Result registers capture the terminating beat so they stay frozen under backpressure.
    load_out = (state_d == DONE) && (state_q != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      sat_q     <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_sat   <= '0;
      out_count <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      if (load_out) begin
        out_data  <= acc_d;
        out_sat   <= sat_d;
        out_count <= cnt_d;
      end
    end
  end

endmodule
